iter_shift_unit: RTL

Multi-cycle shift/rotate execution unit for the datapath ALU, handling SHR, SHRA, SHL, ROR and ROL. The A operand is supplied from RY and the B operand (shift amount) from the bus. The unit shifts by at most SHIFT_STEP bits per clock and signals completion with a start/busy/done handshake. The control sequencer holds its T4 step until done, then moves result into Z low; Z high is written 0.

---
 rtl/iter_shift_unit_pkg.sv | 52 +++++
 rtl/iter_shift_unit_shift_step.sv | 58 +++++
 rtl/iter_shift_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/iter_shift_unit_pkg.sv
// Shared definitions for the iterative shift unit.
// Contents: opcode constants, FSM state encoding, internal shift mode,
// opcode decode helper and the shift-amount width derivation.
package iter_shift_unit_pkg;

    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        M_SHR  = 3'd0,
        M_SHRA = 3'd1,
        M_SHL  = 3'd2,
        M_ROR  = 3'd3,
        M_ROL  = 3'd4
    } shift_mode_t;

    typedef struct packed {
        logic        valid;
        shift_mode_t mode;
    } op_dec_t;

    // Number of shift-amount bits taken from the B operand.
    function automatic int unsigned amt_width(input int unsigned data_width);
        return $clog2(data_width);
    endfunction

    // Map an ALU opcode to a shift mode; non-shift opcodes come back invalid.
    function automatic op_dec_t decode_op(input logic [4:0] op);
        op_dec_t d;
        d.valid = 1'b1;
        d.mode  = M_SHR;
        case (op)
            OP_SHR:  d.mode = M_SHR;
            OP_SHRA: d.mode = M_SHRA;
            OP_SHL:  d.mode = M_SHL;
            OP_ROR:  d.mode = M_ROR;
            OP_ROL:  d.mode = M_ROL;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/iter_shift_unit_shift_step.sv
// Combinational single-step shifter: moves a word by 0..SHIFT_STEP bits.
// Ports: data (word in), mode (shift kind), amt (bits this step),
//        data_out_c (shifted word), carry_c (last bit out / wrapped,
//        present only with ITER_SHIFT_CARRY_EN).
module iter_shift_unit_shift_step
    import iter_shift_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SHIFT_STEP = 4,
    parameter int unsigned STEP_W     = $clog2(SHIFT_STEP + 1)
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  shift_mode_t           mode,
    input  logic [STEP_W-1:0]     amt,
    output logic [DATA_WIDTH-1:0] data_out_c
`ifdef ITER_SHIFT_CARRY_EN
    ,
    output logic                  carry_c
`endif
);

    logic [DATA_WIDTH-1:0] ror;
    logic [DATA_WIDTH-1:0] rol;

    // Rotations; a shift by DATA_WIDTH yields 0, so amt=0 passes data through.
    always_comb begin
        ror = (data >> amt) | (data << (DATA_WIDTH - 32'(amt)));
        rol = (data << amt) | (data >> (DATA_WIDTH - 32'(amt)));
    end

    always_comb begin
        data_out_c = data;
        case (mode)
            M_SHR:   data_out_c = data >> amt;
            M_SHRA:  data_out_c = $unsigned($signed(data) >>> amt);
            M_SHL:   data_out_c = data << amt;
            M_ROR:   data_out_c = ror;
            M_ROL:   data_out_c = rol;
            default: data_out_c = data;
        endcase
    end

`ifdef ITER_SHIFT_CARRY_EN
    // Last bit leaving the right end lands in the rotate-right MSB;
    // last bit leaving the left end lands in the rotate-left LSB.
    always_comb begin
        carry_c = 1'b0;
        if (amt != '0) begin
            case (mode)
                M_SHR, M_SHRA, M_ROR: carry_c = ror[DATA_WIDTH-1];
                M_SHL, M_ROL:         carry_c = rol[0];
                default:              carry_c = 1'b0;
            endcase
        end
    end
`endif

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit (SHR, SHRA, SHL, ROR, ROL), at most
// SHIFT_STEP bits per clock, with a start/busy/done handshake.
// Ports: clock, clear (async active-low), start, opcode, a_in (value),
//        b_in (amount, low AMT_W bits), busy, done, result, illegal_op,
//        carry_out (only when ITER_SHIFT_CARRY_EN is defined).
// Option macro: ITER_SHIFT_CARRY_EN adds the carry_out port and logic.
module iter_shift_unit
    import iter_shift_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SHIFT_STEP = 4
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic [4:0]            opcode,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  illegal_op
`ifdef ITER_SHIFT_CARRY_EN
    ,
    output logic                  carry_out
`endif
);

    localparam int unsigned AMT_W  = amt_width(DATA_WIDTH);
    localparam int unsigned STEP_W = $clog2(SHIFT_STEP + 1);

    state_t                state_q, state_d;
    shift_mode_t           mode_q, mode_d;
    logic [AMT_W-1:0]      remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] result_d;
    logic                  illegal_d, busy_d, done_d;
    logic [STEP_W-1:0]     step_amt;
    logic [AMT_W-1:0]      rem_next;
    logic [DATA_WIDTH-1:0] step_out;
    logic [AMT_W-1:0]      n_amt;
    op_dec_t               dec;

    // Upper amount bits are architecturally ignored.
    logic unused_b_hi;
    assign unused_b_hi = ^b_in[DATA_WIDTH-1:AMT_W];

`ifdef ITER_SHIFT_CARRY_EN
    logic carry_d;
    logic step_carry;
`endif

    // Bits moved this cycle: min(remaining, SHIFT_STEP).
    always_comb begin
        if (32'(remaining_q) > SHIFT_STEP) begin
            step_amt = STEP_W'(SHIFT_STEP);
            rem_next = remaining_q - AMT_W'(SHIFT_STEP);
        end else begin
            step_amt = STEP_W'(remaining_q);
            rem_next = '0;
        end
    end

    iter_shift_unit_shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_STEP (SHIFT_STEP),
        .STEP_W     (STEP_W)
    ) u_step (
        .data       (result),
        .mode       (mode_q),
        .amt        (step_amt),
        .data_out_c (step_out)
`ifdef ITER_SHIFT_CARRY_EN
        ,
        .carry_c    (step_carry)
`endif
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        result_d    = result;
        illegal_d   = illegal_op;
        busy_d      = 1'b0;
        done_d      = 1'b0;
`ifdef ITER_SHIFT_CARRY_EN
        carry_d     = carry_out;
`endif
        dec         = decode_op(opcode);
        n_amt       = b_in[AMT_W-1:0];

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    result_d  = a_in;
                    illegal_d = ~dec.valid;
                    mode_d    = dec.mode;
`ifdef ITER_SHIFT_CARRY_EN
                    carry_d   = 1'b0;
`endif
                    if (!dec.valid || n_amt == '0) begin
                        state_d     = S_DONE;
                        remaining_d = '0;
                        done_d      = 1'b1;
                    end else begin
                        state_d     = S_SHIFT;
                        remaining_d = n_amt;
                        busy_d      = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                result_d    = step_out;
                remaining_d = rem_next;
`ifdef ITER_SHIFT_CARRY_EN
                carry_d     = step_carry;
`endif
                if (rem_next == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; clear discards any operation in flight.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q     <= S_IDLE;
            mode_q      <= M_SHR;
            remaining_q <= '0;
            result      <= '0;
            illegal_op  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef ITER_SHIFT_CARRY_EN
            carry_out   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            result      <= result_d;
            illegal_op  <= illegal_d;
            busy        <= busy_d;
            done        <= done_d;
`ifdef ITER_SHIFT_CARRY_EN
            carry_out   <= carry_d;
`endif
        end
    end

endmodule
